mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters SHALL be: S, default 32, scalar width; V, default 192, vector width; ROM_BASE, default 1000, first ROM address; RAM_BASE, default 31000, first RAM address; RAM_END, default 61015, first address past RAM; LAT, default 1, memory read latency in cycles (1..4).
REQ-002 Ports SHALL be, in order:
 clk  in  1  single clock, all state on rising edge
 rst  in  1  asynchronous, active-low reset
 req_valid  in  1  pipeline request present
 req_ready  out  1  stage can accept request
 req_we  in  1  1=store, 0=load
 req_vec  in  1  1=vector (V-bit), 0=scalar (S-bit)
 req_addr  in  S  byte/word address in unified map
 req_wdata  in  V  store data (scalar uses [S-1:0])
 req_tag  in  4  opaque ID returned with response
 mem_we  out  1  write strobe to memory controller
 mem_vecop  out  1  vector-op select to memory controller
 mem_address  out  S  address to memory controller
 mem_wd  out  V  write data to memory controller
 mem_rd  in  V  read data from memory controller
 resp_valid  out  1  response present
 resp_ready  in  1  writeback accepts response
 resp_data  out  V  load result
 resp_tag  out  4  tag of completed request
 resp_err  out  1  request was out of range / illegal
 busy  out  1  state != IDLE
 err_count  out  8  saturating count of errored requests

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-004 Request handshake SHALL complete on a rising edge with req_valid=1 and req_ready=1; req_ready = (state==IDLE) or (state==RESP and resp_ready=1).
REQ-005 On acceptance, req_we, req_vec, req_addr, req_wdata, req_tag SHALL be registered; later input changes SHALL NOT affect the in-flight request.
REQ-006 Legal load: ROM_BASE <= addr < RAM_END; legal store: RAM_BASE <= addr < RAM_END; all else (incl. addr < ROM_BASE, i.e. instruction space) illegal.
REQ-007 Legal request: accept -> ISSUE (1 cycle) -> WAIT (LAT cycles) -> RESP.
REQ-008 Illegal request: accept -> RESP directly; no memory access; resp_err=1, resp_data=0.
REQ-009 mem_address and mem_vecop SHALL equal the registered addr/vec from ISSUE through last WAIT cycle; 0 in IDLE, RESP, and for illegal requests.
REQ-010 mem_we SHALL be 1 for exactly the ISSUE cycle of a legal store, 0 otherwise; mem_wd SHALL equal registered wdata during ISSUE (scalar: upper V-S bits zero).
REQ-011 Load data SHALL be captured from mem_rd on the edge ending the final WAIT cycle; scalar loads zero-extend mem_rd[S-1:0] to V bits.
REQ-012 Stores SHALL return a response with resp_data=0, resp_err=0.
REQ-013 resp_valid=1 only in RESP; resp_data/tag/err SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-014 RESP with resp_ready=1 and no new request -> IDLE; with resp_ready=1 and accepted request -> ISSUE (legal) or RESP (illegal) on same edge, no bubble.
REQ-015 Latency: legal load accepted on edge 0 SHALL show resp_valid=1 in cycle LAT+2 after that edge; illegal request in cycle 1.
REQ-016 err_count SHALL increment on each accepted illegal request and saturate at 255.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 rst=0 SHALL immediately, independent of clk, force state=IDLE and all outputs to 0 except req_ready=1 (after release, IDLE); err_count=0.
REQ-019 Reset during ISSUE SHALL deassert mem_we in the same cycle; the in-flight request SHALL be dropped with no response.

Verification
REQ-020 Scalar load addr=1005, mem_rd low word=0xDEADBEEF, LAT=1 -> mem_address=1005 cycles 1-2, resp_valid cycle 3, resp_data=0x...0DEADBEEF zero-extended, resp_err=0.
REQ-021 Vector store addr=31010, wdata=192'hA5 pattern -> mem_we=1 exactly cycle 1, mem_vecop=1, mem_wd=pattern; response resp_data=0, resp_err=0.
REQ-022 Store addr=2000 (ROM) and load addr=500 -> no mem_we/mem_address activity, resp_err=1 cycle 1 each, err_count=2; 260 illegal requests -> err_count=255.
REQ-023 resp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready=0; then resp_ready=1 with req_valid=1 -> next request accepted same edge, ISSUE follows.
REQ-024 rst=0 asserted mid-cycle during ISSUE of a store -> mem_we falls before next clk edge, resp_valid never asserts, err_count=0, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_stage.sv
// Load/store stage between the pipeline and the memory controller: range-checks
// each request, drives one memory access, waits LAT cycles and returns a tagged response.
//
// state  | meaning
// IDLE   | no request in flight, ready to accept
// ISSUE  | address/strobe presented to memory for one cycle
// WAIT   | read latency countdown (LAT cycles)
// RESP   | response held until writeback accepts it
module mem_access_stage #(
  parameter int S        = 32,
  parameter int V        = 192,
  parameter int ROM_BASE = 1000,
  parameter int RAM_BASE = 31000,
  parameter int RAM_END  = 61015,
  parameter int LAT      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wdata,
  input  logic [3:0]   req_tag,
  output logic         mem_we,
  output logic         mem_vecop,
  output logic [S-1:0] mem_address,
  output logic [V-1:0] mem_wd,
  input  logic [V-1:0] mem_rd,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [V-1:0] resp_data,
  output logic [3:0]   resp_tag,
  output logic         resp_err,
  output logic         busy,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [S-1:0] L_ROM_BASE = S'(ROM_BASE);
  localparam logic [S-1:0] L_RAM_BASE = S'(RAM_BASE);
  localparam logic [S-1:0] L_RAM_END  = S'(RAM_END);
  localparam logic [1:0]   L_WAIT_TC  = 2'(LAT - 1);

  state_t         r_state, w_next;
  logic           r_we, r_vec, r_err;
  logic [S-1:0]   r_addr;
  logic [V-1:0]   r_wdata, r_data;
  logic [3:0]     r_tag;
  logic [1:0]     r_cnt;
  logic [7:0]     r_err_count;
  logic           w_legal, w_accept;
  logic [V-1:0]   w_wd_fmt, w_rd_fmt;

  // Instruction space below ROM_BASE is never reachable; ROM is read-only.
  assign w_legal  = req_we ? (req_addr >= L_RAM_BASE && req_addr < L_RAM_END)
                           : (req_addr >= L_ROM_BASE && req_addr < L_RAM_END);
  assign w_accept = req_valid && req_ready;

  assign w_wd_fmt = r_vec ? r_wdata : {{(V-S){1'b0}}, r_wdata[S-1:0]};
  assign w_rd_fmt = r_vec ? mem_rd  : {{(V-S){1'b0}}, mem_rd[S-1:0]};

  assign resp_data = r_data;
  assign resp_tag  = r_tag;
  assign resp_err  = r_err;
  assign err_count = r_err_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    mem_we      = 1'b0;
    mem_vecop   = 1'b0;
    mem_address = '0;
    mem_wd      = '0;
    resp_valid  = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        mem_we      = r_we;
        mem_vecop   = r_vec;
        mem_address = r_addr;
        mem_wd      = w_wd_fmt;
        w_next      = ST_WAIT;
      end
      ST_WAIT: begin
        mem_vecop   = r_vec;
        mem_address = r_addr;
        if (r_cnt == 2'd0) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        if (resp_ready) begin
          if (req_valid) w_next = w_legal ? ST_ISSUE : ST_RESP;
          else           w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_vec       <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_vec   <= req_vec;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_tag   <= req_tag;
        r_err   <= !w_legal;
        r_data  <= '0;
        if (!w_legal && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
      if (r_state == ST_ISSUE) r_cnt <= L_WAIT_TC;
      else if (r_state == ST_WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (r_state == ST_WAIT && r_cnt == 2'd0 && !r_we) r_data <= w_rd_fmt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (default parameters, LAT=1): address map,
// latency, back-to-back handshakes, response hold, error saturation and async reset.
module tb_mem_access_stage;
  localparam int S = 32;
  localparam int V = 192;

  logic         clk, rst;
  logic         req_valid, req_ready, req_we, req_vec;
  logic [S-1:0] req_addr;
  logic [V-1:0] req_wdata;
  logic [3:0]   req_tag;
  logic         mem_we, mem_vecop;
  logic [S-1:0] mem_address;
  logic [V-1:0] mem_wd, mem_rd;
  logic         resp_valid, resp_ready;
  logic [V-1:0] resp_data;
  logic [3:0]   resp_tag;
  logic         resp_err, busy;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ec = 0;

  localparam logic [V-1:0] RD  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h3333_3333_CAFE_F00D};
  localparam logic [V-1:0] PAT = {24{8'hA5}};
  localparam logic [V-1:0] W2  = {48{4'h6}};

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_we(mem_we), .mem_vecop(mem_vecop), .mem_address(mem_address), .mem_wd(mem_wd),
    .mem_rd(mem_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic vec, input logic [S-1:0] addr,
                       input logic [V-1:0] wd, input logic [3:0] tag);
    req_valid = 1'b1; req_we = we; req_vec = vec;
    req_addr = addr; req_wdata = wd; req_tag = tag;
  endtask

  // One request from IDLE through to IDLE, with resp_ready held high.
  task automatic do_req(input string nm, input logic we, input logic vec, input logic [S-1:0] addr,
                        input logic [V-1:0] wd, input logic [3:0] tag, input logic exp_err,
                        input logic [V-1:0] exp_data, input logic [V-1:0] exp_wd);
    int lat;
    drive(we, vec, addr, wd, tag);
    tick();
    req_valid = 1'b0;
    req_addr  = '1;
    chk({nm, " mem_we"}, V'(mem_we), V'(we && !exp_err));
    chk({nm, " mem_address"}, V'(mem_address), exp_err ? '0 : V'(addr));
    chk({nm, " mem_wd"}, mem_wd, exp_wd);
    if (exp_err && exp_ec < 255) exp_ec++;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, V'(lat), exp_err ? V'(1) : V'(3));
    chk({nm, " resp_err"}, V'(resp_err), V'(exp_err));
    chk({nm, " resp_data"}, resp_data, exp_data);
    chk({nm, " resp_tag"}, V'(resp_tag), V'(tag));
    chk({nm, " err_count"}, V'(err_count), V'(exp_ec));
    tick();
    chk({nm, " back to idle"}, V'(busy), '0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0; mem_rd = RD; resp_ready = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk("rst req_ready", V'(req_ready), V'(1));
    chk("rst resp_valid", V'(resp_valid), '0);
    chk("rst busy", V'(busy), '0);
    chk("rst err_count", V'(err_count), '0);
    chk("rst mem_we", V'(mem_we), '0);
    #8 rst = 1'b1;
    tick();

    // Scalar load at 1005, upper mem_rd bits must be dropped
    mem_rd = {RD[V-1:32], 32'hDEADBEEF};
    drive(1'b0, 1'b0, 32'd1005, '0, 4'd3);
    tick();
    req_valid = 1'b0; req_addr = 32'd7;
    chk("ld c1 mem_address", V'(mem_address), V'(1005));
    chk("ld c1 resp_valid", V'(resp_valid), '0);
    chk("ld c1 mem_vecop", V'(mem_vecop), '0);
    tick();
    chk("ld c2 mem_address", V'(mem_address), V'(1005));
    tick();
    chk("ld c3 resp_valid", V'(resp_valid), V'(1));
    chk("ld c3 resp_data", resp_data, V'(32'hDEADBEEF));
    chk("ld c3 resp_err", V'(resp_err), '0);
    chk("ld c3 mem_address", V'(mem_address), '0);
    tick();
    chk("ld idle", V'(busy), '0);
    mem_rd = RD;

    // Vector store at 31010
    drive(1'b1, 1'b1, 32'd31010, PAT, 4'd5);
    tick();
    req_valid = 1'b0;
    chk("vst c1 mem_we", V'(mem_we), V'(1));
    chk("vst c1 mem_vecop", V'(mem_vecop), V'(1));
    chk("vst c1 mem_wd", mem_wd, PAT);
    tick();
    chk("vst c2 mem_we", V'(mem_we), '0);
    tick();
    chk("vst c3 resp_valid", V'(resp_valid), V'(1));
    chk("vst c3 resp_data", resp_data, '0);
    chk("vst c3 resp_err", V'(resp_err), '0);
    tick();

    // Illegal store into ROM, then illegal load back-to-back with no bubble
    drive(1'b1, 1'b0, 32'd2000, PAT, 4'd1);
    tick();
    chk("ill st resp_valid", V'(resp_valid), V'(1));
    chk("ill st resp_err", V'(resp_err), V'(1));
    chk("ill st mem_we", V'(mem_we), '0);
    chk("ill st mem_address", V'(mem_address), '0);
    chk("ill st resp_data", resp_data, '0);
    chk("ill st err_count", V'(err_count), V'(1));
    drive(1'b0, 1'b0, 32'd500, '0, 4'd2);
    chk("ill b2b req_ready", V'(req_ready), V'(1));
    tick();
    req_valid = 1'b0;
    chk("ill ld resp_valid", V'(resp_valid), V'(1));
    chk("ill ld resp_tag", V'(resp_tag), V'(2));
    chk("ill ld mem_address", V'(mem_address), '0);
    chk("ill ld err_count", V'(err_count), V'(2));
    tick();
    exp_ec = 2;

    // Address map boundaries
    do_req("ld 999",   1'b0, 1'b0, 32'd999,   '0,  4'd4, 1'b1, '0, '0);
    do_req("ld 1000",  1'b0, 1'b0, 32'd1000,  '0,  4'd6, 1'b0, V'(32'hCAFEF00D), '0);
    do_req("vld 61014",1'b0, 1'b1, 32'd61014, '0,  4'd7, 1'b0, RD, '0);
    do_req("ld 61015", 1'b0, 1'b0, 32'd61015, '0,  4'd8, 1'b1, '0, '0);
    do_req("st 30999", 1'b1, 1'b0, 32'd30999, '1,  4'd9, 1'b1, '0, '0);
    do_req("st 31000", 1'b1, 1'b0, 32'd31000, '1,  4'd10, 1'b0, '0, V'(32'hFFFFFFFF));
    do_req("vst 61014",1'b1, 1'b1, 32'd61014, W2,  4'd11, 1'b0, '0, W2);
    do_req("vst 61015",1'b1, 1'b1, 32'd61015, W2,  4'd12, 1'b1, '0, '0);

    // 260 back-to-back illegal requests saturate the error counter
    drive(1'b0, 1'b0, 32'd500, '0, 4'd13);
    repeat (260) tick();
    req_valid = 1'b0;
    chk("err_count sat", V'(err_count), V'(255));
    tick();

    // Hold the response for 5 cycles with writeback stalled
    resp_ready = 1'b0;
    drive(1'b0, 1'b1, 32'd1000, '0, 4'd9);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    mem_rd = ~RD;
    drive(1'b1, 1'b1, 32'd31000, PAT, 4'd10);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== RD || resp_tag !== 4'd9 || req_ready !== 1'b0) seen++;
      tick();
    end
    chk("hold stable cycles bad", V'(seen), '0);
    chk("hold resp_data", resp_data, RD);
    resp_ready = 1'b1;
    #1;
    chk("release req_ready", V'(req_ready), V'(1));
    tick();
    req_valid = 1'b0;
    chk("b2b issue mem_we", V'(mem_we), V'(1));
    chk("b2b issue mem_address", V'(mem_address), V'(31000));
    chk("b2b issue resp_valid", V'(resp_valid), '0);
    tick();
    tick();
    chk("b2b resp_tag", V'(resp_tag), V'(10));
    tick();

    // Asynchronous reset in the middle of a store's ISSUE cycle
    drive(1'b1, 1'b0, 32'd31020, PAT, 4'd14);
    tick();
    chk("pre-rst mem_we", V'(mem_we), V'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst mid mem_we", V'(mem_we), '0);
    chk("rst mid req_ready", V'(req_ready), V'(1));
    chk("rst mid busy", V'(busy), '0);
    chk("rst mid err_count", V'(err_count), '0);
    req_valid = 1'b0;
    tick();
    #3 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid !== 1'b0 || mem_we !== 1'b0) seen++;
    end
    chk("post-rst activity", V'(seen), '0);
    chk("post-rst req_ready", V'(req_ready), V'(1));
    chk("post-rst err_count", V'(err_count), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
